// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Shares one SDRAM controller port between the CPU path (port A),
//            the SD-card image loader (port B) and periodic refresh. One
//            command per fixed-length slot, read data and a one-cycle ack
//            back to the owner, with forward-progress guarantees for refresh
//            and the loader.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int AW    = 24,
  parameter int CYC   = 8,
  parameter int RDLAT = 6,
  parameter int RFMAX = 3,
  parameter int BMAX  = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ready,
  input  logic          rfReq,
  input  logic          aRd,
  input  logic          aWr,
  input  logic [AW-1:0] aA,
  input  logic [7:0]    aD,
  output logic [7:0]    aQ,
  output logic          aAck,
  input  logic          bRd,
  input  logic          bWr,
  input  logic [AW-1:0] bA,
  input  logic [7:0]    bD,
  output logic [7:0]    bQ,
  output logic          bAck,
  output logic          sdrRf,
  output logic          sdrRd,
  output logic          sdrWr,
  output logic [AW-1:0] sdrA,
  output logic [15:0]   sdrD,
  input  logic [15:0]   sdrQ
);

  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int PW = $clog2(RFMAX + 1);
  localparam int SW = $clog2(BMAX + 1);

  localparam logic [CW-1:0] c_cnt_rd   = CW'(RDLAT);
  localparam logic [CW-1:0] c_cnt_pre  = CW'(CYC - 2);
  localparam logic [CW-1:0] c_cnt_last = CW'(CYC - 1);
  localparam logic [PW-1:0] c_pend_max = PW'(RFMAX);
  localparam logic [SW-1:0] c_stv_max  = SW'(BMAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_A    = 2'd0,
    OWN_B    = 2'd1,
    OWN_RF   = 2'd2,
    OWN_NONE = 2'd3
  } owner_t;

  state_t        state_q, state_d;
  owner_t        own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [SW-1:0] stv_q, stv_d;
  logic [7:0]    aQ_q, aQ_d, bQ_q, bQ_d;
  logic          aAck_q, aAck_d, bAck_q, bAck_d;
  logic          sdrRf_q, sdrRf_d, sdrRd_q, sdrRd_d, sdrWr_q, sdrWr_d;
  logic [AW-1:0] sdrA_q, sdrA_d;
  logic [15:0]   sdrD_q, sdrD_d;

  owner_t        w_gnt;
  logic          w_aReq, w_bReq;
  logic [PW-1:0] w_pend_inc;
  logic          w_unused_sdrq;

  assign w_aReq = aRd | aWr;
  assign w_bReq = bRd | bWr;

  // Only the low byte of the SDRAM word is returned to the 8-bit ports.
  assign w_unused_sdrq = ^sdrQ[15:8];

  // Pick the next slot owner while idle; urgent refresh and a starved loader
  // pre-empt the CPU, leftover refresh only fills otherwise empty slots.
  always_comb begin
    w_gnt = OWN_NONE;
    if (state_q == ST_IDLE && ready) begin
      if (pend_q == c_pend_max)              w_gnt = OWN_RF;
      else if (stv_q >= c_stv_max && w_bReq) w_gnt = OWN_B;
      else if (w_aReq)                       w_gnt = OWN_A;
      else if (w_bReq)                       w_gnt = OWN_B;
      else if (pend_q != '0)                 w_gnt = OWN_RF;
    end
  end

  // Slot sequencing: launch the command on grant, capture read data, ack.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    aQ_d    = aQ_q;
    bQ_d    = bQ_q;
    aAck_d  = 1'b0;
    bAck_d  = 1'b0;
    sdrRf_d = 1'b0;
    sdrRd_d = 1'b0;
    sdrWr_d = 1'b0;
    sdrA_d  = sdrA_q;
    sdrD_d  = sdrD_q;
    case (state_q)
      ST_IDLE: begin
        if (w_gnt != OWN_NONE) begin
          state_d = ST_BUSY;
          own_d   = w_gnt;
          cnt_d   = '0;
          case (w_gnt)
            OWN_A: begin
              // Rd and Wr together is treated as a write.
              rd_d    = ~aWr;
              sdrRd_d = ~aWr;
              sdrWr_d = aWr;
              sdrA_d  = aA;
              sdrD_d  = {aD, aD};
            end
            OWN_B: begin
              rd_d    = ~bWr;
              sdrRd_d = ~bWr;
              sdrWr_d = bWr;
              sdrA_d  = bA;
              sdrD_d  = {bD, bD};
            end
            default: begin
              rd_d    = 1'b0;
              sdrRf_d = 1'b1;
              sdrA_d  = '0;
              sdrD_d  = '0;
            end
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_cnt_rd && rd_q) begin
          if (own_q == OWN_A)      aQ_d = sdrQ[7:0];
          else if (own_q == OWN_B) bQ_d = sdrQ[7:0];
        end
        // Ack is registered, so it is launched one count early.
        if (cnt_q == c_cnt_pre) begin
          aAck_d = (own_q == OWN_A);
          bAck_d = (own_q == OWN_B);
        end
        if (cnt_q == c_cnt_last) state_d = ST_IDLE;
      end
    endcase
  end

  // Pending-refresh count: saturating increment first, then grant decrement.
  always_comb begin
    w_pend_inc = pend_q;
    if (rfReq && pend_q != c_pend_max) w_pend_inc = pend_q + 1'b1;
    pend_d = w_pend_inc;
    if (w_gnt == OWN_RF) pend_d = w_pend_inc - 1'b1;
    if (!ready) pend_d = '0;
  end

  // Loader starvation: count grants lost while requesting, clear on a win.
  always_comb begin
    stv_d = stv_q;
    if (w_gnt == OWN_B) begin
      stv_d = '0;
    end else if (w_gnt != OWN_NONE && w_bReq && stv_q != c_stv_max) begin
      stv_d = stv_q + 1'b1;
    end
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_NONE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      pend_q  <= '0;
      stv_q   <= '0;
      aQ_q    <= '0;
      bQ_q    <= '0;
      aAck_q  <= 1'b0;
      bAck_q  <= 1'b0;
      sdrRf_q <= 1'b0;
      sdrRd_q <= 1'b0;
      sdrWr_q <= 1'b0;
      sdrA_q  <= '0;
      sdrD_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      stv_q   <= stv_d;
      aQ_q    <= aQ_d;
      bQ_q    <= bQ_d;
      aAck_q  <= aAck_d;
      bAck_q  <= bAck_d;
      sdrRf_q <= sdrRf_d;
      sdrRd_q <= sdrRd_d;
      sdrWr_q <= sdrWr_d;
      sdrA_q  <= sdrA_d;
      sdrD_q  <= sdrD_d;
    end
  end

  assign aQ    = aQ_q;
  assign bQ    = bQ_q;
  assign aAck  = aAck_q;
  assign bAck  = bAck_q;
  assign sdrRf = sdrRf_q;
  assign sdrRd = sdrRd_q;
  assign sdrWr = sdrWr_q;
  assign sdrA  = sdrA_q;
  assign sdrD  = sdrD_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter: directed scenarios with
//            literal expectations plus randomized traffic, all compared every
//            cycle against a slot-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int AW    = 24;
  localparam int CYC   = 8;
  localparam int RDLAT = 6;
  localparam int RFMAX = 3;
  localparam int BMAX  = 4;

  localparam int S_RD = 0, S_WR = 1, S_RF = 2, S_A = 3, S_D = 4;
  localparam int S_AACK = 5, S_AQ = 6, S_BACK = 7, S_BQ = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic          rfReq = 1'b0;
  logic          aRd = 1'b0, aWr = 1'b0, bRd = 1'b0, bWr = 1'b0;
  logic [AW-1:0] aA = '0, bA = '0;
  logic [7:0]    aD = '0, bD = '0;
  logic [15:0]   sdrQ = '0;
  logic [7:0]    aQ, bQ;
  logic          aAck, bAck, sdrRf, sdrRd, sdrWr;
  logic [AW-1:0] sdrA;
  logic [15:0]   sdrD;

  sdram_arbiter #(
    .AW(AW), .CYC(CYC), .RDLAT(RDLAT), .RFMAX(RFMAX), .BMAX(BMAX)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready), .rfReq(rfReq),
    .aRd(aRd), .aWr(aWr), .aA(aA), .aD(aD), .aQ(aQ), .aAck(aAck),
    .bRd(bRd), .bWr(bWr), .bA(bA), .bD(bD), .bQ(bQ), .bAck(bAck),
    .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr),
    .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Literal expectations keyed by cycle*16 + signal id.
  logic [31:0] dir [int];
  string sname [9] = '{"sdrRd", "sdrWr", "sdrRf", "sdrA", "sdrD",
                       "aAck", "aQ", "bAck", "bQ"};

  // Reference model: a slot is remembered by its grant cycle; strobe,
  // read sample, ack and next idle cycle are fixed offsets from it.
  int            m_g = -100;
  int            m_own = 0;   // 0 = A, 1 = B, 2 = refresh
  int            m_kind = 0;  // 1 = read, 2 = write, 3 = refresh
  int            m_pend = 0;
  int            m_stv = 0;
  logic [7:0]    m_aq = '0, m_bq = '0;
  logic [AW-1:0] m_sa = '0;
  logic [15:0]   m_sd = '0;

  function automatic logic [31:0] dut_sig(input int s);
    case (s)
      S_RD:    dut_sig = {31'd0, sdrRd};
      S_WR:    dut_sig = {31'd0, sdrWr};
      S_RF:    dut_sig = {31'd0, sdrRf};
      S_A:     dut_sig = {8'd0, sdrA};
      S_D:     dut_sig = {16'd0, sdrD};
      S_AACK:  dut_sig = {31'd0, aAck};
      S_AQ:    dut_sig = {24'd0, aQ};
      S_BACK:  dut_sig = {31'd0, bAck};
      default: dut_sig = {24'd0, bQ};
    endcase
  endfunction

  always @(negedge clock) begin : cmp
    logic [60:0] act, expv;
    logic        e_rf, e_rd, e_wr, e_aack, e_back, a_req, b_req;
    int          gnt, key;
    e_rf = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_aack = 1'b0; e_back = 1'b0;
    if (reset) begin
      m_g = -100; m_kind = 0; m_pend = 0; m_stv = 0;
      m_aq = '0; m_bq = '0; m_sa = '0; m_sd = '0;
    end else begin
      e_rd   = (cyc == m_g + 1) && (m_kind == 1);
      e_wr   = (cyc == m_g + 1) && (m_kind == 2);
      e_rf   = (cyc == m_g + 1) && (m_kind == 3);
      e_aack = (cyc == m_g + CYC) && (m_own == 0);
      e_back = (cyc == m_g + CYC) && (m_own == 1);
    end
    act  = {aQ, aAck, bQ, bAck, sdrRf, sdrRd, sdrWr, sdrA, sdrD};
    expv = {m_aq, e_aack, m_bq, e_back, e_rf, e_rd, e_wr, m_sa, m_sd};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL model cyc=%0d got=%h want=%h", cyc, act, expv);
    end
    for (int s = 0; s < 9; s++) begin
      key = cyc * 16 + s;
      if (dir.exists(key)) begin
        checks++;
        if (dut_sig(s) !== dir[key]) begin
          failures++;
          $display("FAIL directed %s cyc=%0d got=%h want=%h",
                   sname[s], cyc, dut_sig(s), dir[key]);
        end
      end
    end
    if (!reset) begin
      if (cyc == m_g + 1 + RDLAT && m_kind == 1) begin
        if (m_own == 0) m_aq = sdrQ[7:0];
        else            m_bq = sdrQ[7:0];
      end
      a_req = aRd | aWr;
      b_req = bRd | bWr;
      gnt = -1;
      if (cyc > m_g + CYC && ready) begin
        if (m_pend == RFMAX)             gnt = 2;
        else if (m_stv >= BMAX && b_req) gnt = 1;
        else if (a_req)                  gnt = 0;
        else if (b_req)                  gnt = 1;
        else if (m_pend > 0)             gnt = 2;
      end
      if (gnt >= 0) begin
        m_g = cyc;
        m_own = gnt;
        case (gnt)
          0: begin m_kind = aWr ? 2 : 1; m_sa = aA; m_sd = {aD, aD}; end
          1: begin m_kind = bWr ? 2 : 1; m_sa = bA; m_sd = {bD, bD}; end
          default: begin m_kind = 3; m_sa = '0; m_sd = '0; end
        endcase
      end
      m_pend = m_pend + int'(rfReq);
      if (m_pend > RFMAX) m_pend = RFMAX;
      if (gnt == 2) m_pend = m_pend - 1;
      if (!ready) m_pend = 0;
      if (gnt == 1) m_stv = 0;
      else if (gnt >= 0 && b_req && m_stv < BMAX) m_stv = m_stv + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input int c, input int s, input logic [31:0] v);
    dir[c * 16 + s] = v;
  endtask

  initial begin
    int   t, t0, t1, op;
    logic a_busy, b_busy, a_ackp, b_ackp;

    // Reset state
    tick();
    ex(cyc, S_RD, 0); ex(cyc, S_A, 0); ex(cyc, S_AQ, 0); ex(cyc, S_AACK, 0);
    repeat (2) tick();
    reset = 1'b0; ready = 1'b1;
    repeat (3) tick();

    // 1: single read by A
    t = cyc; aRd = 1'b1; aA = 24'h001234; sdrQ = 16'h00A5;
    ex(t + 1, S_RD, 1); ex(t + 1, S_A, 'h1234); ex(t + 2, S_RD, 0);
    ex(t + 8, S_AACK, 1); ex(t + 8, S_AQ, 'hA5); ex(t + 9, S_AACK, 0);
    repeat (9) tick();
    aRd = 1'b0;

    // 2: simultaneous writes, A first then B
    repeat (2) tick();
    t = cyc; aWr = 1'b1; aD = 8'h11; aA = 24'h000010;
    bWr = 1'b1; bD = 8'h22; bA = 24'h000020;
    ex(t + 1, S_WR, 1); ex(t + 1, S_D, 'h1111); ex(t + 8, S_AACK, 1);
    ex(t + 8, S_BACK, 0);
    ex(t + 10, S_WR, 1); ex(t + 10, S_D, 'h2222); ex(t + 10, S_A, 'h20);
    ex(t + 17, S_BACK, 1);
    repeat (9) tick();
    aWr = 1'b0;
    repeat (9) tick();
    bWr = 1'b0;

    // 3: A hogs the port, B wins the fifth grant
    repeat (2) tick();
    t = cyc; aRd = 1'b1; aA = 24'h000100; bRd = 1'b1; bA = 24'h000200;
    for (int k = 0; k < 4; k++) begin
      ex(t + 1 + 9 * k, S_RD, 1); ex(t + 1 + 9 * k, S_A, 'h100);
      ex(t + 8 + 9 * k, S_AACK, 1);
    end
    ex(t + 37, S_A, 'h200); ex(t + 44, S_BACK, 1); ex(t + 46, S_A, 'h100);
    repeat (54) tick();
    aRd = 1'b0; bRd = 1'b0;

    // 4: refresh becomes urgent while A is busy
    repeat (2) tick();
    t = cyc; aRd = 1'b1; aA = 24'h000300;
    repeat (2) tick();
    rfReq = 1'b1;
    repeat (3) tick();
    rfReq = 1'b0;
    ex(t + 10, S_RF, 1); ex(t + 10, S_RD, 0);
    ex(t + 19, S_RD, 1); ex(t + 19, S_A, 'h300); ex(t + 26, S_AACK, 1);
    ex(t + 28, S_RF, 1); ex(t + 37, S_RF, 1); ex(t + 46, S_RF, 0);
    repeat (22) tick();
    aRd = 1'b0;
    repeat (21) tick();

    // 5: no grants while not ready; earlier refresh request is dropped
    t0 = cyc; ready = 1'b0; aRd = 1'b1; aA = 24'h000400; rfReq = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      ex(t0 + i, S_RD, 0); ex(t0 + i, S_RF, 0);
    end
    tick();
    rfReq = 1'b0;
    repeat (5) tick();
    t1 = cyc; ready = 1'b1;
    ex(t1 + 1, S_RD, 1); ex(t1 + 1, S_A, 'h400); ex(t1 + 8, S_AACK, 1);
    ex(t1 + 10, S_RF, 0); ex(t1 + 11, S_RF, 0);
    repeat (9) tick();
    aRd = 1'b0;
    repeat (3) tick();

    // 6: reset in the middle of a read slot
    repeat (2) tick();
    t = cyc; aRd = 1'b1; aA = 24'h000777;
    ex(t + 1, S_RD, 1);
    ex(t + 4, S_A, 0); ex(t + 4, S_AQ, 0); ex(t + 8, S_AACK, 0);
    ex(t + 7, S_RD, 1); ex(t + 7, S_A, 'h777); ex(t + 14, S_AACK, 1);
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (9) tick();
    aRd = 1'b0;
    repeat (3) tick();

    // Randomized traffic obeying the request/ack handshake
    a_busy = 1'b0; b_busy = 1'b0; a_ackp = 1'b0; b_ackp = 1'b0;
    repeat (3000) begin
      tick();
      rfReq = ($urandom_range(0, 11) == 0);
      sdrQ  = 16'($urandom);
      ready = ($urandom_range(0, 19) != 0);
      if (a_busy && a_ackp) a_busy = 1'b0;
      if (!a_busy) begin
        if ($urandom_range(0, 2) != 0) begin
          op = int'($urandom_range(0, 2));
          aRd = (op != 1); aWr = (op != 0);
          aA = AW'($urandom); aD = 8'($urandom);
          a_busy = 1'b1;
        end else begin
          aRd = 1'b0; aWr = 1'b0;
        end
      end
      if (b_busy && b_ackp) b_busy = 1'b0;
      if (!b_busy) begin
        if ($urandom_range(0, 1) != 0) begin
          op = int'($urandom_range(0, 2));
          bRd = (op != 1); bWr = (op != 0);
          bA = AW'($urandom); bD = 8'($urandom);
          b_busy = 1'b1;
        end else begin
          bRd = 1'b0; bWr = 1'b0;
        end
      end
      a_ackp = aAck;
      b_ackp = bAck;
    end
    tick();
    aRd = 1'b0; aWr = 1'b0; bRd = 1'b0; bWr = 1'b0; rfReq = 1'b0; ready = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
